fft_butterfly: RTL and testbench
================================

FFT_BUTTERFLY -- requirements
Module: fft_butterfly

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input operand set valid.
- in_ready  out  1  block accepts the operand set this cycle.
- in_a  in  32  {re[31:16], im[15:0]}, signed Q1.15.
- in_b  in  32  {re, im}, signed Q1.15.
- in_tw  in  32  twiddle {re, im}, signed Q1.15, as produced by the FFT1024 twiddle lookup.
- in_idx  in  10  tag, passed through unchanged.
- in_scale  in  1  1 = halve the outputs for this operand set.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_x  out  32  {re, im} = A + B*W.
- out_y  out  32  {re, im} = A - B*W.
- out_idx  out  10  tag of the result.

Function
REQ-003 The datapath SHALL be a 3-stage pipeline.
- S1 registers the inputs.
- S2 registers the four 32-bit signed products br*wr, bi*wi, br*wi, bi*wr.
- S3 combines, rounds, adds or subtracts, and registers the outputs.
REQ-004 Latency SHALL be 3 cycles from an in_valid&&in_ready edge to out_valid, with no stall.
REQ-005 Define enable = !out_valid || out_ready. All stages SHALL advance only when enable=1. in_ready SHALL equal enable (combinational).
REQ-006 Each stage SHALL carry a valid bit. Bubbles SHALL propagate, and throughput SHALL be one operand set per cycle when out_ready=1.
REQ-007 While out_valid=1 and out_ready=0, out_x, out_y and out_idx SHALL be held stable. No operand set SHALL be lost, duplicated or reordered.
REQ-008 The rounded product SHALL be computed as follows.
- tr = (br*wr - bi*wi + 2^14) >>> 15
- ti = (br*wi + bi*wr + 2^14) >>> 15
- Use 33-bit signed intermediates and keep a 17-bit signed result.
REQ-009 Sums SHALL be formed per component at 18-bit signed width: sx = a + t, sy = a - t.
REQ-010 Scaling SHALL be applied per component.
- If the stage's scale bit is 1: value = s >>> 1 (arithmetic shift, floor).
- Otherwise: value = s.
REQ-011 Narrowing of each component to 16 bits SHALL follow REQ-014.
REQ-012 in_scale and in_idx SHALL travel with their operand set through all stages.

Reset
REQ-013 On rst=1, the following SHALL clear immediately, regardless of clk:
- all stage valid bits;
- out_x, out_y and out_idx to 0;
- out_valid to 0.
in_ready SHALL be 1 while rst is asserted and after release. In-flight operand sets SHALL be discarded.

Configuration
REQ-014 Macro FFT_BUTTERFLY_SAT_EN SHALL control narrowing to 16 bits.
- Defined: each component saturates to [-32768, 32767].
- Undefined: each component keeps its low 16 bits (two's-complement wrap).
- No other behaviour SHALL differ.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Basic: a=(1000,0), b=(1000,0), w=(32767,0), scale=0, idx=5, out_ready=1. Result exactly 3 cycles later: x=(2000,0), y=(0,0), idx=5.
- Quadrature twiddle: a=(0,0), b=(1000,0), w=(0,-32767). Result: x=(0,-1000), y=(0,1000).
- Overflow: a=(32767,0), b=(32767,0), w=(32767,0).
  - scale=0: x.re=32767 with FFT_BUTTERFLY_SAT_EN; x.re=-3 without it.
  - scale=1: x.re=32766 in both builds.
- Backpressure: 5 back-to-back sets with idx 0..4; drop out_ready for 4 cycles after the first result. in_ready=0 during the stall, outputs stable, then idx 0..4 delivered in order, no gaps or duplicates.
- Reset mid-stream: assert rst asynchronously with 2 sets in flight. out_valid=0 and outputs 0 before the next edge. No stale result appears after release. The first new set's result arrives 3 cycles after its acceptance.

Source files
------------

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X = A + B*W, Y = A - B*W, Q1.15 complex, 3-stage pipeline.
// Build option FFT_BUTTERFLY_SAT_EN: saturate outputs to 16 bits instead of wrapping.
module fft_butterfly (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_tw,
  input  logic [9:0]  in_idx,
  input  logic        in_scale,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [9:0]  out_idx
);

  // Handshake: a set moves on a rising edge when valid && ready are both high.
  // The whole pipeline advances as one unit whenever the output register is
  // empty or being drained, so in_ready is that same enable, combinationally.
  logic enable;
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  // Stage 1: registered operands
  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [31:0] s1_tw;
  logic [9:0]  s1_idx;
  logic        s1_scale;

  // Stage 2: partial products plus the operands still needed downstream
  logic               s2_valid;
  logic [31:0]        s2_a;
  logic [9:0]         s2_idx;
  logic               s2_scale;
  logic signed [31:0] s2_p_rr;
  logic signed [31:0] s2_p_ii;
  logic signed [31:0] s2_p_ri;
  logic signed [31:0] s2_p_ir;

  logic signed [15:0] b_re;
  logic signed [15:0] b_im;
  logic signed [15:0] w_re;
  logic signed [15:0] w_im;

  assign b_re = s1_b[31:16];
  assign b_im = s1_b[15:0];
  assign w_re = s1_tw[31:16];
  assign w_im = s1_tw[15:0];

  // Round-half-up of a Q2.30 sum/difference back to Q1.15, kept at 17 bits.
  function automatic logic signed [16:0] round_q15(
    input logic signed [31:0] p,
    input logic signed [31:0] q,
    input logic               sub
  );
    logic signed [32:0] acc;
    if (sub) acc = 33'(p) - 33'(q) + 33'sd16384;
    else     acc = 33'(p) + 33'(q) + 33'sd16384;
    return 17'(acc >>> 15);
  endfunction

  function automatic logic [15:0] narrow(input logic signed [17:0] v);
`ifdef FFT_BUTTERFLY_SAT_EN
    if (v > 18'sd32767)       return 16'h7fff;
    else if (v < -18'sd32768) return 16'h8000;
    else                      return v[15:0];
`else
    return 16'(v);
`endif
  endfunction

  // One output component: a +/- t at 18 bits, optional halving, then narrowing.
  function automatic logic [15:0] combine(
    input logic signed [15:0] a,
    input logic signed [16:0] t,
    input logic               sub,
    input logic               half
  );
    logic signed [17:0] s;
    if (sub) s = 18'(a) - 18'(t);
    else     s = 18'(a) + 18'(t);
    if (half) s = s >>> 1;
    return narrow(s);
  endfunction

  logic signed [16:0] t_re;
  logic signed [16:0] t_im;
  logic signed [15:0] a_re;
  logic signed [15:0] a_im;

  assign t_re = round_q15(s2_p_rr, s2_p_ii, 1'b1);
  assign t_im = round_q15(s2_p_ri, s2_p_ir, 1'b0);
  assign a_re = s2_a[31:16];
  assign a_im = s2_a[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tw    <= '0;
      s1_idx   <= '0;
      s1_scale <= 1'b0;
    end else if (enable) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_tw    <= in_tw;
        s1_idx   <= in_idx;
        s1_scale <= in_scale;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_idx   <= '0;
      s2_scale <= 1'b0;
      s2_p_rr  <= '0;
      s2_p_ii  <= '0;
      s2_p_ri  <= '0;
      s2_p_ir  <= '0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a     <= s1_a;
        s2_idx   <= s1_idx;
        s2_scale <= s1_scale;
        s2_p_rr  <= 32'(b_re) * 32'(w_re);
        s2_p_ii  <= 32'(b_im) * 32'(w_im);
        s2_p_ri  <= 32'(b_re) * 32'(w_im);
        s2_p_ir  <= 32'(b_im) * 32'(w_re);
      end
    end
  end

  // Output register: only reloads on a real set, so a bubble leaves the last
  // result in place with out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_idx   <= '0;
    end else if (enable) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_x   <= {combine(a_re, t_re, 1'b0, s2_scale),
                    combine(a_im, t_im, 1'b0, s2_scale)};
        out_y   <= {combine(a_re, t_re, 1'b1, s2_scale),
                    combine(a_im, t_im, 1'b1, s2_scale)};
        out_idx <= s2_idx;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: directed scenarios plus randomized traffic against
// an arithmetic reference model; honours FFT_BUTTERFLY_SAT_EN like the design.
module tb_fft_butterfly;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_tw;
  logic [9:0]  in_idx;
  logic        in_scale;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [9:0]  out_idx;

  fft_butterfly dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tw    (in_tw),
    .in_idx   (in_idx),
    .in_scale (in_scale),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_idx  (out_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrap17(input longint v);
    longint r;
    r = v;
    while (r > 65535)  r -= 131072;
    while (r < -65536) r += 131072;
    return r;
  endfunction

  function automatic logic [15:0] fit16(input longint v, input logic sc);
    longint r;
    r = sc ? (v >>> 1) : v;
`ifdef FFT_BUTTERFLY_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  // Returns {x, y}
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] w, input logic sc);
    longint ar, ai, br, bi, wr, wi, tr, ti;
    ar = sx16(a[31:16]); ai = sx16(a[15:0]);
    br = sx16(b[31:16]); bi = sx16(b[15:0]);
    wr = sx16(w[31:16]); wi = sx16(w[15:0]);
    tr = wrap17((br * wr - bi * wi + 16384) >>> 15);
    ti = wrap17((br * wi + bi * wr + 16384) >>> 15);
    return {fit16(ar + tr, sc), fit16(ai + ti, sc), fit16(ar - tr, sc), fit16(ai - ti, sc)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [73:0] exp_q[$];   // {idx, x, y}
  int          acc_cyc;
  int          out_cyc;
  int          n_out = 0;
  logic [31:0] last_x;
  logic [31:0] last_y;
  logic [9:0]  last_idx;
  logic        hold = 1'b0;
  logic [31:0] h_x;
  logic [31:0] h_y;
  logic [9:0]  h_idx;

  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", {out_x, out_y}, {h_x, h_y});
        check("hold_idx", 64'(out_idx), 64'(h_idx));
      end
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back({in_idx, model(in_a, in_b, in_tw, in_scale)});
        acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        logic [73:0] e;
        out_cyc  = cyc;
        n_out++;
        last_x   = out_x;
        last_y   = out_y;
        last_idx = out_idx;
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_idx", 64'(out_idx), 64'(e[73:64]));
          check("out_x", 64'(out_x), 64'(e[63:32]));
          check("out_y", 64'(out_y), 64'(e[31:0]));
        end
      end
      hold  = out_valid && !out_ready;
      h_x   = out_x;
      h_y   = out_y;
      h_idx = out_idx;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the set was taken.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                      input logic [9:0] idx, input logic sc);
    int guard;
    in_a = a; in_b = b; in_tw = w; in_idx = idx; in_scale = sc;
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 1000);
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'h0000;
      3:       return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  logic rand_done;
  int   base_out;

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tw = '0; in_idx = '0; in_scale = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic
    send(32'h03E8_0000, 32'h03E8_0000, 32'h7FFF_0000, 10'd5, 1'b0);
    drain();
    check("basic_latency", 64'(out_cyc - acc_cyc), 64'd3);
    check("basic_x", 64'(last_x), 64'h07D0_0000);
    check("basic_y", 64'(last_y), 64'h0000_0000);
    check("basic_idx", 64'(last_idx), 64'd5);

    // quadrature twiddle: w = (0, -32767)
    send(32'h0000_0000, 32'h03E8_0000, 32'h0000_8001, 10'd6, 1'b0);
    drain();
    check("quad_x", 64'(last_x), 64'h0000_FC18);
    check("quad_y", 64'(last_y), 64'h0000_03E8);

    // overflow, unscaled then scaled
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 10'd7, 1'b0);
    drain();
`ifdef FFT_BUTTERFLY_SAT_EN
    check("ovf_x_re", 64'(last_x[31:16]), 64'h7FFF);
`else
    check("ovf_x_re", 64'(last_x[31:16]), 64'hFFFD);
`endif
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 10'd8, 1'b1);
    drain();
    check("ovf_scaled_x_re", 64'(last_x[31:16]), 64'h7FFE);

    // backpressure: 5 back-to-back, stall 4 cycles after first result
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send({rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()}, 10'(i), 1'($urandom_range(0, 1)));
      end
      begin
        int guard;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!out_valid && guard < 100);
        check("bp_first_out", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_out - base_out), 64'd5);
    check("bp_last_idx", 64'(last_idx), 64'd4);

    // reset mid-stream
    send(32'h1000_2000, 32'h3000_4000, 32'h5A82_A57E, 10'd10, 1'b0);
    send(32'h1111_2222, 32'h3333_4444, 32'h7FFF_0000, 10'd11, 1'b0);
    send(32'h0100_0200, 32'h0300_0400, 32'h0000_8001, 10'd12, 1'b1);
    out_ready = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_x", 64'(out_x), 64'd0);
    check("midrst_y", 64'(out_y), 64'd0);
    check("midrst_idx", 64'(out_idx), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(32'h03E8_0000, 32'h03E8_0000, 32'h7FFF_0000, 10'd99, 1'b0);
    drain();
    check("post_rst_latency", 64'(out_cyc - acc_cyc), 64'd3);
    check("post_rst_idx", 64'(last_idx), 64'd99);

    // randomized traffic with random gaps and backpressure
    rand_done = 1'b0;
    base_out  = n_out;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send({rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()},
               10'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_count", 64'(n_out - base_out), 64'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
